// File: rtl/mips_cpu_pkg.sv
// Shared ALU control encodings, used by the ALU and the CPU controller.
package mips_cpu_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_XOR   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_ADD   = 4'b0100,
        ALU_SUB   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_MULT  = 4'b1010,
        ALU_MULTU = 4'b1011,
        ALU_DIV   = 4'b1100,
        ALU_DIVU  = 4'b1101,
        ALU_HILO  = 4'b1110,
        ALU_NOP   = 4'b1111
    } alu_op_e;

    // sa[1:0] sub-select for ALU_HILO
    localparam logic [1:0] HILO_MFHI = 2'b00;
    localparam logic [1:0] HILO_MFLO = 2'b01;
    localparam logic [1:0] HILO_MTHI = 2'b10;
    localparam logic [1:0] HILO_MTLO = 2'b11;

endpackage

// File: rtl/mips_cpu_alu.sv
// MIPS ALU: combinational result path plus the HI/LO register pair written
// by multiply, divide and move-to ops.
module mips_cpu_alu
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  control,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  sa,
    output logic [31:0] r,
    output logic        zero
);

    logic [31:0] hi, lo, hi_nxt, lo_nxt;
    alu_op_e     op;
    logic [63:0] prod_s, prod_u;
    logic        div_signed;
    logic [31:0] a_mag, b_mag, div_n, div_d, uq, ur, q, rem;

    assign op = alu_op_e'(control);

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'b0, a} * {32'b0, b};

    // Signed divide runs on magnitudes through the same unsigned divider, so
    // 0x80000000 / -1 falls out as 0x80000000 rem 0 without overflow.
    assign div_signed = (op == ALU_DIV);
    assign a_mag      = a[31] ? (~a + 32'd1) : a;
    assign b_mag      = b[31] ? (~b + 32'd1) : b;
    assign div_n      = div_signed ? a_mag : a;
    assign div_d      = div_signed ? b_mag : b;
    assign uq         = (div_d == 32'd0) ? 32'd0 : div_n / div_d;
    assign ur         = (div_d == 32'd0) ? 32'd0 : div_n % div_d;
    assign q          = (div_signed && (a[31] ^ b[31])) ? (~uq + 32'd1) : uq;
    assign rem        = (div_signed && a[31]) ? (~ur + 32'd1) : ur;

    always_comb begin
        r      = 32'd0;
        hi_nxt = hi;
        lo_nxt = lo;
        case (op)
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLTU: r = {31'd0, a < b};
            ALU_SLL:  r = b << sa;
            ALU_SRL:  r = b >> sa;
            ALU_SRA:  r = $signed(b) >>> sa;
            ALU_MULT: begin
                hi_nxt = prod_s[63:32];
                lo_nxt = prod_s[31:0];
            end
            ALU_MULTU: begin
                hi_nxt = prod_u[63:32];
                lo_nxt = prod_u[31:0];
            end
            ALU_DIV, ALU_DIVU: begin
                if (b != 32'd0) begin
                    hi_nxt = rem;
                    lo_nxt = q;
                end
            end
            ALU_HILO: begin
                case (sa[1:0])
                    HILO_MFHI: r = hi;
                    HILO_MFLO: r = lo;
                    HILO_MTHI: hi_nxt = a;
                    HILO_MTLO: lo_nxt = a;
                    default:   r = 32'd0;
                endcase
            end
            default: r = 32'd0;
        endcase
    end

    assign zero = (r == 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

endmodule

// File: tb/tb_mips_cpu_alu.sv
// Directed bench for mips_cpu_alu: a reference model checks r/zero every
// cycle, and literal expectations pin the model on the key vectors.
module tb_mips_cpu_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  control;
    logic [31:0] a, b;
    logic [4:0]  sa;
    logic [31:0] r;
    logic        zero;

    int n_vec = 0;
    int n_err = 0;
    bit run   = 1'b0;

    logic [31:0] mhi = 32'd0, mlo = 32'd0;

    mips_cpu_alu dut (
        .clk(clk), .reset(reset), .control(control),
        .a(a), .b(b), .sa(sa), .r(r), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_r(input logic [3:0] c, input logic [31:0] x,
                                            input logic [31:0] y, input logic [4:0] s);
        case (c)
            4'd0:  return x & y;
            4'd1:  return x | y;
            4'd2:  return x ^ y;
            4'd3:  return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            4'd4:  return x + y;
            4'd5:  return x - y;
            4'd6:  return (x < y) ? 32'd1 : 32'd0;
            4'd7:  return y << s;
            4'd8:  return y >> s;
            4'd9:  return 32'(int'(y) >>> s);
            4'd14: return (s[1:0] == 2'd0) ? mhi : (s[1:0] == 2'd1) ? mlo : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Reference HI/LO state, using plain 64-bit arithmetic.
    always @(posedge clk) begin
        longint sp, sx, sy;
        longint unsigned up;
        if (reset) begin
            mhi = 32'd0;
            mlo = 32'd0;
        end else begin
            sx = longint'(int'(a));
            sy = longint'(int'(b));
            case (control)
                4'd10: begin sp = sx * sy; mhi = sp[63:32]; mlo = sp[31:0]; end
                4'd11: begin
                    up = longint'({32'd0, a}) * longint'({32'd0, b});
                    mhi = up[63:32]; mlo = up[31:0];
                end
                4'd12: if (b != 0) begin sp = sx / sy; mlo = sp[31:0]; sp = sx % sy; mhi = sp[31:0]; end
                4'd13: if (b != 0) begin mlo = a / b; mhi = a % b; end
                4'd14: begin
                    if (sa[1:0] == 2'd2) mhi = a;
                    if (sa[1:0] == 2'd3) mlo = a;
                end
                default: ;
            endcase
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        logic [31:0] er;
        if (run) begin
            er = model_r(control, a, b, sa);
            n_vec++;
            if (r !== er || zero !== (er == 32'd0)) begin
                n_err++;
                $display("FAIL model ctl=%b a=%h b=%h sa=%0d: got r=%h zero=%b, want r=%h zero=%b",
                         control, a, b, sa, r, zero, er, (er == 32'd0));
            end
        end
    end

    task automatic drive(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] s, input logic rs);
        @(posedge clk);
        #2;
        control = c; a = x; b = y; sa = s; reset = rs;
    endtask

    task automatic expect_r(input string name, input logic [31:0] want);
        @(negedge clk);
        #1;
        n_vec++;
        if (r !== want || zero !== (want == 32'd0)) begin
            n_err++;
            $display("FAIL %s: got r=%h zero=%b, want r=%h zero=%b", name, r, zero, want, (want == 32'd0));
        end
    endtask

    task automatic mf(input string name, input logic [31:0] want_hi, input logic [31:0] want_lo);
        drive(4'd14, 32'd0, 32'd0, 5'd0, 1'b0);
        expect_r({name, "_hi"}, want_hi);
        drive(4'd14, 32'd0, 32'd0, 5'd1, 1'b0);
        expect_r({name, "_lo"}, want_lo);
    endtask

    initial begin
        control = 4'd15; a = '0; b = '0; sa = '0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        run = 1'b1;
        expect_r("default_in_reset", 32'd0);
        mf("reset", 32'd0, 32'd0);

        drive(4'd4, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0); expect_r("add_wrap", 32'd0);
        drive(4'd5, 32'd5, 32'd7, 5'd0, 1'b0);        expect_r("sub_neg", 32'hFFFFFFFE);
        drive(4'd3, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0); expect_r("slt", 32'd1);
        drive(4'd6, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0); expect_r("sltu", 32'd0);
        drive(4'd0, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 1'b0); expect_r("and", 32'h00F0F000);
        drive(4'd1, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 1'b0); expect_r("or", 32'hFFF0FFF0);
        drive(4'd2, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 1'b0); expect_r("xor", 32'hFF000FF0);
        drive(4'd7, 32'd0, 32'h80000010, 5'd4, 1'b0); expect_r("sll", 32'h00000100);
        drive(4'd8, 32'd0, 32'h80000010, 5'd4, 1'b0); expect_r("srl", 32'h08000001);
        drive(4'd9, 32'd0, 32'h80000010, 5'd4, 1'b0); expect_r("sra", 32'hF8000001);
        drive(4'd15, 32'h1234, 32'h5678, 5'd3, 1'b0); expect_r("default", 32'd0);

        drive(4'd10, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0); expect_r("mult_r", 32'd0);
        mf("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
        drive(4'd11, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0);
        drive(4'd11, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0);
        mf("multu_held", 32'h00000002, 32'hFFFFFFFA);

        drive(4'd12, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b0);
        mf("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        drive(4'd13, 32'hFFFFFFF9, 32'd0, 5'd0, 1'b0);
        mf("divu_by0", 32'hFFFFFFFF, 32'hFFFFFFFD);
        drive(4'd12, 32'h12345678, 32'd0, 5'd0, 1'b0);
        mf("div_by0", 32'hFFFFFFFF, 32'hFFFFFFFD);
        drive(4'd13, 32'd100, 32'd7, 5'd0, 1'b0);
        mf("divu", 32'd2, 32'd14);
        drive(4'd12, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b0);
        mf("div_ovf", 32'd0, 32'h80000000);
        drive(4'd12, 32'd7, 32'hFFFFFFFE, 5'd0, 1'b0);
        mf("div_negdivisor", 32'd1, 32'hFFFFFFFD);

        drive(4'd14, 32'h12345678, 32'd0, 5'd2, 1'b0);
        drive(4'd14, 32'h9ABCDEF0, 32'd0, 5'd3, 1'b0);
        mf("mt", 32'h12345678, 32'h9ABCDEF0);
        drive(4'd15, 32'd0, 32'd0, 5'd0, 1'b1);
        mf("after_reset", 32'd0, 32'd0);
        drive(4'd14, 32'h12345678, 32'd0, 5'd2, 1'b0);
        drive(4'd14, 32'h9ABCDEF0, 32'd0, 5'd3, 1'b1);
        mf("reset_vs_mtlo", 32'd0, 32'd0);
        drive(4'd10, 32'h00010000, 32'h00010000, 5'd0, 1'b1);
        mf("reset_vs_mult", 32'd0, 32'd0);

        // Mixed sweep, checked by the model only.
        for (int i = 0; i < 64; i++) begin
            drive(4'(i % 16), $urandom, (i % 5 == 0) ? 32'd0 : $urandom, 5'($urandom), 1'b0);
            if (i % 16 >= 10 && i % 16 <= 13) begin
                drive(4'd14, 32'd0, 32'd0, 5'd0, 1'b0);
                drive(4'd14, 32'd0, 32'd0, 5'd1, 1'b0);
            end
        end

        @(posedge clk);
        #2;
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_cpu_alu.md
MIPS_CPU_ALU -- requirements
Module: mips_cpu_alu

Interface
REQ-001 Parameters SHALL be none; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
REQ-004 control  input  4  operation select (encodings in REQ-010).
REQ-005 a  input  32  operand A (rs value).
REQ-006 b  input  32  operand B (rt value or sign-extended immediate).
REQ-007 sa  input  5  shift amount; sub-select for HI/LO access ops.
REQ-008 r  output  32  result, combinational from control, a, b, sa, HI and LO.
REQ-009 zero  output  1  high iff r == 32'h00000000, combinational.

Function
REQ-010 control encodings SHALL be:
- 0000 AND: a&b
- 0001 OR: a|b
- 0010 XOR: a^b
- 0011 SLT: signed a<b ? 1 : 0
- 0100 ADD: a+b
- 0101 SUB: a-b
- 0110 SLTU: unsigned a<b ? 1 : 0
- 0111 SLL: b<<sa
- 1000 SRL: b>>sa logical
- 1001 SRA: b>>sa arithmetic
- 1010 MULT, 1011 MULTU, 1100 DIV, 1101 DIVU
- 1110 HI/LO access
- 1111 DEFAULT
REQ-011 ADD/SUB SHALL wrap modulo 2^32 with no overflow flag or trap.
REQ-012 Shifts SHALL use sa only; callers needing variable shifts drive sa from rs[4:0].
REQ-013 MULT/MULTU SHALL form the 64-bit signed/unsigned product of a and b; at the clock edge, HI <= product[63:32] and LO <= product[31:0]; r = 0.
REQ-014 DIV/DIVU SHALL form the signed/unsigned quotient and remainder of a/b; at the clock edge, LO <= quotient (signed truncates toward zero) and HI <= remainder (sign follows dividend); r = 0.
REQ-015 DIV/DIVU with b == 0 SHALL leave HI and LO unchanged; r = 0.
REQ-016 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-017 Control 1110 SHALL decode sa[1:0]:
- 00 MFHI: r = HI
- 01 MFLO: r = LO
- 10 MTHI: HI <= a at the edge, r = 0
- 11 MTLO: LO <= a at the edge, r = 0
REQ-018 DEFAULT (1111) SHALL give r = 0, zero = 1, and leave HI/LO unchanged.
REQ-019 HI/LO writes SHALL be idempotent when control and operands are held for several cycles; the same value is rewritten each cycle.
REQ-020 Non-HI/LO operations SHALL have zero latency; the HI/LO effect SHALL be visible via MFHI/MFLO on the cycle after the write edge.

Reset
REQ-021 When reset is high at a clock edge, HI and LO SHALL be 0; reset overrides any simultaneous HI/LO write.
REQ-022 r and zero SHALL hold no reset state; they follow the inputs (with control = 1111, r = 0 and zero = 1).
REQ-023 Reset asserted mid-operation SHALL discard the pending HI/LO update.

Structure
REQ-024 The 4-bit control encoding enum SHALL live in shared package mips_cpu_pkg, imported by mips_cpu_alu and the CPU controller.
REQ-025 mips_cpu_alu SHALL contain no sub-modules.
REQ-026 HI and LO SHALL be the only registers in mips_cpu_alu.
REQ-027 mips_cpu_registers is a separate peer block and SHALL NOT be part of this module.

Verification
REQ-028 ADD: a=0xFFFFFFFF, b=1 -> r=0, zero=1; SUB: a=5, b=7 -> r=0xFFFFFFFE, zero=0.
REQ-029 SLT: a=0xFFFFFFFF, b=1 -> r=1; SLTU with the same operands -> r=0.
REQ-030 Shifts with b=0x80000010, sa=4:
- SLL -> r=0x00000100
- SRL -> r=0x08000001
- SRA -> r=0xF8000001
REQ-031 MULT a=0xFFFFFFFE (-2), b=3 for one edge, then MFHI -> 0xFFFFFFFF and MFLO -> 0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; a following DIVU with b=0 -> HI/LO unchanged.
REQ-033 MTHI a=0x12345678 and MTLO a=0x9ABCDEF0, then reset high for one edge -> MFHI=0 and MFLO=0; a simultaneous reset and MTLO edge -> LO=0.
